// File: rtl/store_lane_aligner.sv
// -----------------------------------------------------------------------------
// store_lane_aligner
//
// Sequential store formatter for the data-memory bus. It accepts one MEM-stage
// store (SB/SH/SW/SD plus byte address), places the sized data on the correct
// byte lanes and generates per-byte write enables. It then issues the store as
// one bus beat, or as two beats when the access crosses a word boundary.
//
// Parameters
//   DATA_WIDTH   bus/word width in bits (32 or 64)
//   ADDR_WIDTH   byte-address width
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   StoreValidM  store request valid
//   StoreReadyM  unit can accept a request (high only in IDLE)
//   StoreSrcM    size: 00 SW, 01 SB, 10 SH, 11 SD (64-bit bus only)
//   AddrM        byte address of the store
//   WriteDataM   store data, LSB-justified
//   BusValid     bus beat valid
//   BusReady     bus accepts the beat
//   BusAddr      word-aligned beat address
//   BusWData     lane-aligned beat data, disabled lanes zero
//   BusByteEn    per-byte write enable
//   StoreDoneM   one-cycle pulse after the final beat handshake
//   StoreFaultM  one-cycle pulse: store rejected, no bus traffic
//
// Configuration macro
//   MISALIGN_TRAP_EN  when defined, any word-crossing store faults instead of
//                     being split into two beats.
// -----------------------------------------------------------------------------
module store_lane_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    StoreValidM,
    output logic                    StoreReadyM,
    input  logic [1:0]              StoreSrcM,
    input  logic [ADDR_WIDTH-1:0]   AddrM,
    input  logic [DATA_WIDTH-1:0]   WriteDataM,
    output logic                    BusValid,
    input  logic                    BusReady,
    output logic [ADDR_WIDTH-1:0]   BusAddr,
    output logic [DATA_WIDTH-1:0]   BusWData,
    output logic [DATA_WIDTH/8-1:0] BusByteEn,
    output logic                    StoreDoneM,
    output logic                    StoreFaultM
);

    localparam int BYTES     = DATA_WIDTH / 32'sd8;
    localparam int OFFW      = $clog2(BYTES);
    localparam bit SD_LEGAL  = (DATA_WIDTH == 32'sd64);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Number of bytes written by each size encoding.
    function automatic logic [3:0] size_bytes(input logic [1:0] src);
        logic [3:0] n;
        case (src)
            2'b00:   n = 4'd4;
            2'b01:   n = 4'd1;
            2'b10:   n = 4'd2;
            2'b11:   n = 4'd8;
            default: n = 4'd4;
        endcase
        return n;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic                    bus_valid_r, bus_valid_nxt_s;
    logic [ADDR_WIDTH-1:0]   bus_addr_r, bus_addr_nxt_s;
    logic [DATA_WIDTH-1:0]   bus_wdata_r, bus_wdata_nxt_s;
    logic [BYTES-1:0]        bus_byte_en_r, bus_byte_en_nxt_s;
    logic [ADDR_WIDTH-1:0]   hi_addr_r, hi_addr_nxt_s;
    logic [DATA_WIDTH-1:0]   hi_wdata_r, hi_wdata_nxt_s;
    logic [BYTES-1:0]        hi_byte_en_r, hi_byte_en_nxt_s;
    logic                    split_r, split_nxt_s;
    logic                    done_r, done_nxt_s;
    logic                    fault_r, fault_nxt_s;

    logic [OFFW-1:0]         off_s;
    logic [3:0]              size_s;
    logic [DATA_WIDTH-1:0]   mask_s;
    logic [2*DATA_WIDTH-1:0] data2_s;
    logic [2*BYTES-1:0]      en2_s;
    logic                    split_s;
    logic                    sd_illegal_s;
    logic                    fault_s;
    logic [ADDR_WIDTH-1:0]   base_addr_s;

    // Request decode: the data and enables are formed double-width so that the
    // high half directly becomes the second beat of a crossing store.
    assign off_s        = AddrM[OFFW-1:0];
    assign size_s       = size_bytes(StoreSrcM);
    // A shift by the full width yields zero, so SW on 32-bit / SD on 64-bit
    // naturally produce an all-ones mask.
    assign mask_s       = ~({DATA_WIDTH{1'b1}} << {size_s, 3'b000});
    assign data2_s      = {{DATA_WIDTH{1'b0}}, WriteDataM & mask_s} << {off_s, 3'b000};
    assign en2_s        = (~({(2*BYTES){1'b1}} << size_s)) << off_s;
    assign split_s      = |en2_s[2*BYTES-1:BYTES];
    assign sd_illegal_s = (StoreSrcM == 2'b11) && !SD_LEGAL;
    assign base_addr_s  = {AddrM[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

`ifdef MISALIGN_TRAP_EN
    assign fault_s = sd_illegal_s | split_s;
`else
    assign fault_s = sd_illegal_s;
`endif

    // Next-state and next-output logic; every bus output is registered.
    always_comb begin
        state_nxt_s       = state_r;
        bus_valid_nxt_s   = bus_valid_r;
        bus_addr_nxt_s    = bus_addr_r;
        bus_wdata_nxt_s   = bus_wdata_r;
        bus_byte_en_nxt_s = bus_byte_en_r;
        hi_addr_nxt_s     = hi_addr_r;
        hi_wdata_nxt_s    = hi_wdata_r;
        hi_byte_en_nxt_s  = hi_byte_en_r;
        split_nxt_s       = split_r;
        done_nxt_s        = 1'b0;
        fault_nxt_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (StoreValidM) begin
                    if (fault_s) begin
                        state_nxt_s = ST_FAULT;
                        fault_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s       = ST_BEAT0;
                        bus_valid_nxt_s   = 1'b1;
                        bus_addr_nxt_s    = base_addr_s;
                        bus_wdata_nxt_s   = data2_s[DATA_WIDTH-1:0];
                        bus_byte_en_nxt_s = en2_s[BYTES-1:0];
                        // Wraps modulo 2^ADDR_WIDTH by construction.
                        hi_addr_nxt_s     = base_addr_s + ADDR_WIDTH'(BYTES);
                        hi_wdata_nxt_s    = data2_s[2*DATA_WIDTH-1:DATA_WIDTH];
                        hi_byte_en_nxt_s  = en2_s[2*BYTES-1:BYTES];
                        split_nxt_s       = split_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BEAT0, ST_BEAT1: begin
                if (BusReady) begin
                    if ((state_r == ST_BEAT0) && split_r) begin
                        state_nxt_s       = ST_BEAT1;
                        bus_addr_nxt_s    = hi_addr_r;
                        bus_wdata_nxt_s   = hi_wdata_r;
                        bus_byte_en_nxt_s = hi_byte_en_r;
                    end else begin
                        state_nxt_s       = ST_IDLE;
                        bus_valid_nxt_s   = 1'b0;
                        bus_addr_nxt_s    = {ADDR_WIDTH{1'b0}};
                        bus_wdata_nxt_s   = {DATA_WIDTH{1'b0}};
                        bus_byte_en_nxt_s = {BYTES{1'b0}};
                        split_nxt_s       = 1'b0;
                        done_nxt_s        = 1'b1;
                    end
                end else begin
                    // Stalled: hold the beat stable.
                    state_nxt_s = state_r;
                end
            end
            ST_FAULT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                bus_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            bus_valid_r   <= 1'b0;
            bus_addr_r    <= {ADDR_WIDTH{1'b0}};
            bus_wdata_r   <= {DATA_WIDTH{1'b0}};
            bus_byte_en_r <= {BYTES{1'b0}};
            hi_addr_r     <= {ADDR_WIDTH{1'b0}};
            hi_wdata_r    <= {DATA_WIDTH{1'b0}};
            hi_byte_en_r  <= {BYTES{1'b0}};
            split_r       <= 1'b0;
            done_r        <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            bus_valid_r   <= bus_valid_nxt_s;
            bus_addr_r    <= bus_addr_nxt_s;
            bus_wdata_r   <= bus_wdata_nxt_s;
            bus_byte_en_r <= bus_byte_en_nxt_s;
            hi_addr_r     <= hi_addr_nxt_s;
            hi_wdata_r    <= hi_wdata_nxt_s;
            hi_byte_en_r  <= hi_byte_en_nxt_s;
            split_r       <= split_nxt_s;
            done_r        <= done_nxt_s;
            fault_r       <= fault_nxt_s;
        end
    end

    assign StoreReadyM = (state_r == ST_IDLE);
    assign BusValid    = bus_valid_r;
    assign BusAddr     = bus_addr_r;
    assign BusWData    = bus_wdata_r;
    assign BusByteEn   = bus_byte_en_r;
    assign StoreDoneM  = done_r;
    assign StoreFaultM = fault_r;

endmodule
